// File: rtl/si5340_init_sequencer.sv
// Si5340 bring-up sequencer: streams the config ROM into register
// requests, honours delay words, then polls status until ready.
module si5340_init_sequencer #(
  parameter int          WORD_NUMBER = 512,
  parameter int          CLK_FREQ_HZ = 50_000_000,
  parameter logic [15:0] DELAY_MARK  = 16'hFFFF,
  parameter logic [15:0] STATUS_ADDR = 16'h00FE,
  parameter logic [7:0]  READY_VALUE = 8'h0F,
  parameter int          POLL_TRIES  = 16,
  parameter int          POLL_GAP    = 5000,
  localparam int AW = (WORD_NUMBER > 1) ? $clog2(WORD_NUMBER) : 1
) (
  input  logic          clk_i,
  input  logic          arstn_i,
  input  logic          start_i,
  output logic [AW-1:0] rom_addr_o,
  input  logic [23:0]   rom_data_i,
  output logic          req_valid_o,
  input  logic          req_ready_i,
  output logic          req_rw_o,
  output logic [15:0]   req_addr_o,
  output logic [7:0]    req_data_o,
  input  logic          rsp_valid_i,
  input  logic          rsp_nack_i,
  input  logic [7:0]    rsp_data_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          error_o,
  output logic [1:0]    err_code_o,
  output logic [AW-1:0] err_index_o
);

  localparam int TICKS = CLK_FREQ_HZ / 1000;
  localparam int TW = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam int CW = $clog2(POLL_TRIES + 1);
  localparam int GW = (POLL_GAP > 0) ? $clog2(POLL_GAP + 1) : 1;
  localparam int PRE = (TICKS > 5) ? 5 : 0;

  localparam logic [AW-1:0] LAST = AW'(WORD_NUMBER - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS - 1);
  localparam logic [TW-1:0] TICK_PRE = TW'(PRE);
  localparam logic [CW-1:0] TRY_MAX = CW'(POLL_TRIES);
  localparam logic [GW-1:0] GAP_LAST =
    GW'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, ISSUE, WAIT_RSP, DELAY,
    POLL_ISSUE, POLL_WAIT, POLL_GAP_S, DONE, ERROR
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   idx_q;
  logic [7:0]      ms_q;
  logic [TW-1:0]   tick_q;
  logic [CW-1:0]   try_q;
  logic [GW-1:0]   gap_q;
  logic            rw_q;
  logic [15:0]     addr_q;
  logic [7:0]      data_q;
  logic [1:0]      code_q;
  logic [AW-1:0]   eidx_q;

  logic            is_mark;
  logic            tick_end;
  logic            delay_end;
  logic            word_last;
  logic            poll_ok;
  logic [CW-1:0]   try_inc;
  logic            tries_out;
  logic            gap_end;
  logic            advance;
  logic            restart;

  assign is_mark   = rom_data_i[23:8] == DELAY_MARK;
  assign tick_end  = tick_q == TICK_LAST;
  assign delay_end = (ms_q == 8'd0) ||
                     (ms_q == 8'd1 && tick_end);
  assign word_last = idx_q == LAST;
  assign poll_ok   = !rsp_nack_i && rsp_data_i == READY_VALUE;
  assign try_inc   = try_q + 1'b1;
  assign tries_out = try_inc == TRY_MAX;
  assign gap_end   = gap_q == GAP_LAST;
  assign advance   =
    (state_q == WAIT_RSP && rsp_valid_i && !rsp_nack_i) ||
    (state_q == DELAY && delay_end);
  assign restart   = start_i &&
    (state_q == IDLE || state_q == DONE || state_q == ERROR);

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE, ERROR:
        if (start_i) state_d = FETCH;
      FETCH:  state_d = DECODE;
      DECODE: state_d = is_mark ? DELAY : ISSUE;
      ISSUE:
        if (req_ready_i) state_d = WAIT_RSP;
      WAIT_RSP:
        if (rsp_valid_i) begin
          if (rsp_nack_i)     state_d = ERROR;
          else if (word_last) state_d = POLL_ISSUE;
          else                state_d = FETCH;
        end
      DELAY:
        if (delay_end)
          state_d = word_last ? POLL_ISSUE : FETCH;
      POLL_ISSUE:
        if (req_ready_i) state_d = POLL_WAIT;
      POLL_WAIT:
        if (rsp_valid_i) begin
          if (poll_ok)        state_d = DONE;
          else if (tries_out) state_d = ERROR;
          else                state_d = POLL_GAP_S;
        end
      POLL_GAP_S:
        if (gap_end) state_d = POLL_ISSUE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      idx_q  <= '0;
      ms_q   <= '0;
      tick_q <= '0;
      try_q  <= '0;
      gap_q  <= '0;
      rw_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      code_q <= '0;
      eidx_q <= '0;
    end else begin
      if (restart) begin
        idx_q  <= '0;
        code_q <= '0;
        eidx_q <= '0;
      end
      if (state_q == DECODE) begin
        if (is_mark) begin
          ms_q   <= rom_data_i[7:0];
          // first ms absorbs fetch/decode overhead: next request
          // lands N ms after the previous response
          tick_q <= TICK_PRE;
        end else begin
          addr_q <= rom_data_i[23:8];
          data_q <= rom_data_i[7:0];
          rw_q   <= 1'b0;
        end
      end
      if (state_q == WAIT_RSP && rsp_valid_i && rsp_nack_i) begin
        code_q <= 2'b01;
        eidx_q <= idx_q;
      end
      if (state_q == DELAY && !delay_end) begin
        if (tick_end) begin
          tick_q <= '0;
          ms_q   <= ms_q - 8'd1;
        end else begin
          tick_q <= tick_q + 1'b1;
        end
      end
      if (advance) begin
        if (word_last) begin
          try_q  <= '0;
          rw_q   <= 1'b1;
          addr_q <= STATUS_ADDR;
          data_q <= 8'h00;
        end else begin
          idx_q <= idx_q + 1'b1;
        end
      end
      if (state_q == POLL_WAIT && rsp_valid_i && !poll_ok) begin
        try_q <= try_inc;
        gap_q <= '0;
        if (tries_out) code_q <= 2'b10;
      end
      if (state_q == POLL_GAP_S) gap_q <= gap_q + 1'b1;
    end
  end

  always_comb begin
    req_valid_o = 1'b0;
    busy_o      = 1'b1;
    done_o      = 1'b0;
    error_o     = 1'b0;
    unique case (state_q)
      ISSUE, POLL_ISSUE: req_valid_o = 1'b1;
      IDLE:  busy_o = 1'b0;
      DONE: begin
        busy_o = 1'b0;
        done_o = 1'b1;
      end
      ERROR: begin
        busy_o  = 1'b0;
        error_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign rom_addr_o  = idx_q;
  assign req_rw_o    = rw_q;
  assign req_addr_o  = addr_q;
  assign req_data_o  = data_q;
  assign err_code_o  = code_q;
  assign err_index_o = eidx_q;

endmodule

// File: tb/tb_si5340_init_sequencer.sv
// Directed bench for si5340_init_sequencer: ROM model, downstream
// responder with request scoreboard, timing windows.
module tb_si5340_init_sequencer;

  typedef struct {
    logic        rw;
    logic [15:0] addr;
    logic [7:0]  data;
  } req_t;

  logic        clk = 1'b0;
  logic        arstn;
  logic        start;
  logic [1:0]  rom_addr;
  logic [23:0] rom_q;
  logic        req_valid;
  logic        req_ready;
  logic        req_rw;
  logic [15:0] req_addr;
  logic [7:0]  req_data;
  logic        rsp_valid;
  logic        rsp_nack;
  logic [7:0]  rsp_data;
  logic        busy;
  logic        done;
  logic        error;
  logic [1:0]  err_code;
  logic [1:0]  err_index;

  logic [23:0] rom [4];
  req_t        exp_q[$];
  logic [8:0]  poll_q[$];
  int          req_cyc[$];
  int          rsp_cyc[$];
  int          cyc = 0;
  int          tests = 0;
  int          failed = 0;
  int          n_req = 0;
  int          n_wr = 0;
  int          nack_at = -1;
  logic        rsp_due = 1'b0;
  logic        due_nack;
  logic [7:0]  due_data;

  si5340_init_sequencer #(
    .WORD_NUMBER(4),
    .CLK_FREQ_HZ(10_000),
    .POLL_TRIES(3),
    .POLL_GAP(8)
  ) dut (
    .clk_i(clk),
    .arstn_i(arstn),
    .start_i(start),
    .rom_addr_o(rom_addr),
    .rom_data_i(rom_q),
    .req_valid_o(req_valid),
    .req_ready_i(req_ready),
    .req_rw_o(req_rw),
    .req_addr_o(req_addr),
    .req_data_o(req_data),
    .rsp_valid_i(rsp_valid),
    .rsp_nack_i(rsp_nack),
    .rsp_data_i(rsp_data),
    .busy_o(busy),
    .done_o(done),
    .error_o(error),
    .err_code_o(err_code),
    .err_index_o(err_index)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge clk) rom_q <= rom[rom_addr];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_range(input string tag, input int obs,
                           input int lo, input int hi);
    tests++;
    assert (obs >= lo && obs <= hi) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d..%0d",
             tag, obs, lo, hi);
    end
  endtask

  function automatic logic [31:0] outs();
    return {req_valid, busy, done, error, err_code,
            err_index, rom_addr, req_rw, req_data};
  endfunction

  // downstream stage: one-cycle response the cycle after accept
  initial begin
    rsp_valid = 1'b0;
    rsp_nack  = 1'b0;
    rsp_data  = 8'h00;
    forever begin
      @(negedge clk);
      #1;
      rsp_valid = 1'b0;
      rsp_nack  = 1'b0;
      rsp_data  = 8'h00;
      if (!arstn) begin
        rsp_due = 1'b0;
      end else begin
        if (rsp_due) begin
          rsp_valid = 1'b1;
          rsp_nack  = due_nack;
          rsp_data  = due_data;
          rsp_cyc.push_back(cyc);
          rsp_due = 1'b0;
        end
        if (req_valid && req_ready) begin
          req_t e;
          logic [8:0] p;
          req_cyc.push_back(cyc);
          n_req++;
          chk("req_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("req_payload", {req_rw, req_addr, req_data},
                {e.rw, e.addr, e.data});
          end
          if (req_rw) begin
            p = (poll_q.size() > 0) ? poll_q.pop_front() : 9'h000;
            due_nack = p[8];
            due_data = p[7:0];
          end else begin
            due_nack = (n_wr == nack_at);
            due_data = 8'h00;
            n_wr++;
          end
          rsp_due = 1'b1;
        end
      end
    end
  end

  task automatic push(input logic rw, input logic [15:0] a,
                      input logic [7:0] d);
    req_t e;
    e.rw = rw;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic push_cfg(input int nwr);
    logic [23:0] w;
    for (int i = 0; i < nwr; i++) begin
      w = rom[i];
      push(1'b0, w[23:8], w[7:0]);
    end
  endtask

  task automatic load_rom(input logic [23:0] w0, input logic [23:0] w1,
                          input logic [23:0] w2, input logic [23:0] w3);
    rom[0] = w0;
    rom[1] = w1;
    rom[2] = w2;
    rom[3] = w3;
  endtask

  task automatic prep();
    n_req = 0;
    n_wr = 0;
    nack_at = -1;
    exp_q.delete();
    poll_q.delete();
    req_cyc.delete();
    rsp_cyc.delete();
  endtask

  task automatic start_seq();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input int budget, input string tag);
    int n = 0;
    while (!(done || error) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_in_time"}, n < budget, 1);
  endtask

  initial begin
    int d;
    int n;
    arstn = 1'b0;
    start = 1'b0;
    req_ready = 1'b1;
    load_rom(24'h0B2468, 24'h0B2502, 24'h05020C, 24'h000110);
    repeat (3) @(negedge clk);
    chk("reset_outputs", outs(), 0);
    chk("reset_addr", req_addr, 0);
    arstn = 1'b1;

    // plain stream, first poll ready
    prep();
    poll_q.push_back(9'h00F);
    push_cfg(4);
    push(1'b1, 16'h00FE, 8'h00);
    start_seq();
    chk("t1_busy_after_start", busy, 1);
    wait_end(300, "t1");
    chk("t1_done_err", {done, error}, 2'b10);
    chk("t1_reqs", n_req, 5);
    chk("t1_queue_empty", exp_q.size(), 0);
    @(negedge clk);
    chk("t1_busy_low", busy, 0);

    // delay words, ignored start, second poll read ready
    prep();
    load_rom(24'h0B2468, 24'hFFFF05, 24'h0B2502, 24'hFFFF00);
    poll_q.push_back(9'h000);
    poll_q.push_back(9'h00F);
    push(1'b0, 16'h0B24, 8'h68);
    push(1'b0, 16'h0B25, 8'h02);
    push(1'b1, 16'h00FE, 8'h00);
    push(1'b1, 16'h00FE, 8'h00);
    start_seq();
    chk("t2_done_cleared", done, 0);
    repeat (20) @(negedge clk);
    chk("t2_in_delay", {busy, rom_addr}, 3'b101);
    start_seq();
    chk("t2_start_ignored", {busy, rom_addr}, 3'b101);
    wait_end(400, "t2");
    chk("t2_done_err", {done, error}, 2'b10);
    chk("t2_reqs", n_req, 4);
    chk("t2_queue_empty", exp_q.size(), 0);
    d = req_cyc[1] - rsp_cyc[0];
    chk_range("t2_delay5_cycles", d, 50, 53);
    d = req_cyc[2] - rsp_cyc[1];
    chk_range("t2_delay0_cycles", d, 1, 9);
    d = req_cyc[3] - req_cyc[2];
    chk_range("t2_poll_spacing", d, 8, 1000);

    // status never ready: three reads then timeout
    prep();
    load_rom(24'h0B2468, 24'h0B2502, 24'h05020C, 24'h000110);
    push_cfg(4);
    repeat (3) push(1'b1, 16'h00FE, 8'h00);
    start_seq();
    wait_end(400, "t3");
    chk("t3_flags", {done, error, err_code}, 4'b0110);
    chk("t3_reqs", n_req, 7);
    d = req_cyc[5] - req_cyc[4];
    chk_range("t3_spacing_a", d, 8, 1000);
    d = req_cyc[6] - req_cyc[5];
    chk_range("t3_spacing_b", d, 8, 1000);
    repeat (30) @(negedge clk);
    chk("t3_no_more_reqs", n_req, 7);

    // NACK on word 2
    prep();
    nack_at = 2;
    push_cfg(3);
    start_seq();
    chk("t4_error_cleared", {error, err_code}, 3'b000);
    wait_end(300, "t4");
    chk("t4_flags", {done, error, err_code}, 4'b0101);
    chk("t4_index", err_index, 2);
    repeat (30) @(negedge clk);
    chk("t4_no_more_reqs", n_req, 3);
    chk("t4_valid_low", req_valid, 0);

    // ready stall, then NACKed poll counted as a try
    prep();
    poll_q.push_back(9'h100);
    poll_q.push_back(9'h00F);
    push_cfg(4);
    push(1'b1, 16'h00FE, 8'h00);
    push(1'b1, 16'h00FE, 8'h00);
    req_ready = 1'b0;
    start_seq();
    n = 0;
    while (!req_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t5_valid_seen", req_valid, 1);
    repeat (20) begin
      chk("t5_stall_hold", {req_valid, req_rw, req_addr, req_data},
          {1'b1, 1'b0, 16'h0B24, 8'h68});
      @(negedge clk);
    end
    chk("t5_no_accept", n_req, 0);
    req_ready = 1'b1;
    wait_end(400, "t5");
    chk("t5_done_err", {done, error}, 2'b10);
    chk("t5_reqs", n_req, 6);

    // reset in the middle of a delay, then a clean rerun
    prep();
    load_rom(24'h0B2468, 24'hFFFF05, 24'h0B2502, 24'hFFFF00);
    push(1'b0, 16'h0B24, 8'h68);
    start_seq();
    repeat (20) @(negedge clk);
    chk("t6_in_delay", {busy, rom_addr}, 3'b101);
    arstn = 1'b0;
    #1;
    chk("t6_reset_outputs", outs(), 0);
    chk("t6_reset_addr", req_addr, 0);
    repeat (2) @(negedge clk);
    arstn = 1'b1;
    prep();
    poll_q.push_back(9'h00F);
    push(1'b0, 16'h0B24, 8'h68);
    push(1'b0, 16'h0B25, 8'h02);
    push(1'b1, 16'h00FE, 8'h00);
    start_seq();
    wait_end(400, "t6");
    chk("t6_done_err", {done, error}, 2'b10);
    chk("t6_reqs", n_req, 3);
    chk("t6_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/si5340_init_sequencer.md
Name: si5340_init_sequencer

Overview:
- Upstream control stage for Si5340 bring-up. Walks the configuration ROM word by word and issues one register-access request per word to the downstream register-access/I2C loader stage.
- Handles in-stream delay marker words, such as the post-preamble wait.
- After the last word, polls the device status register until the device reports ready. Reports done/error to the system controller.

Parameters:
WORD_NUMBER, 512, number of 24-bit ROM words; word = [23:8] register address, [7:0] data
CLK_FREQ_HZ, 50_000_000, clk_i frequency; one ms tick = CLK_FREQ_HZ/1000 cycles
DELAY_MARK, 16'hFFFF, address value marking a delay word; its data field is the delay in ms (0..255)
STATUS_ADDR, 16'h00FE, status register polled after the config stream
READY_VALUE, 8'h0F, status value meaning device ready
POLL_TRIES, 16, maximum status reads before timeout error
POLL_GAP, 5000, idle cycles between consecutive status reads

Ports:
clk_i  in  1  clock
arstn_i  in  1  reset, asynchronous, active-low
start_i  in  1  single-cycle pulse; starts a sequence
rom_addr_o  out  $clog2(WORD_NUMBER)  ROM read address
rom_data_i  in  24  ROM data; synchronous ROM, valid one cycle after rom_addr_o
req_valid_o  out  1  request valid
req_ready_i  in  1  downstream accepts request
req_rw_o  out  1  0 = write, 1 = read
req_addr_o  out  16  register address
req_data_o  out  8  write data (0 for reads)
rsp_valid_i  in  1  single-cycle pulse; response for the outstanding request
rsp_nack_i  in  1  qualified by rsp_valid_i; device NACK
rsp_data_i  in  8  qualified by rsp_valid_i; read data
busy_o  out  1  sequence in progress
done_o  out  1  sequence completed OK; level, held until next start
error_o  out  1  sequence aborted; level, held until next start
err_code_o  out  2  01 = NACK on config write, 10 = status poll timeout
err_index_o  out  $clog2(WORD_NUMBER)  ROM index of the failing write

Behaviour:
- Reset values: all outputs 0; state IDLE; word index 0; try counter 0.
- States: IDLE, FETCH, DECODE, ISSUE, WAIT_RSP, DELAY, POLL_ISSUE, POLL_WAIT, POLL_GAP, DONE, ERROR.
- IDLE/DONE/ERROR:
  - start_i -> FETCH.
  - Clear index, done_o, error_o, err_code_o, err_index_o.
  - start_i in any other state is ignored.
- FETCH: drive rom_addr_o = index -> DECODE.
- DECODE: sample rom_data_i.
  - If [23:8] == DELAY_MARK -> DELAY, loading ms count = [7:0].
  - Otherwise register addr/data, rw = 0 -> ISSUE.
- ISSUE:
  - req_valid_o = 1; req_* held stable until req_ready_i is sampled high.
  - Handshake cycle -> WAIT_RSP; req_valid_o drops the next cycle.
  - Exactly one request is outstanding at a time.
- WAIT_RSP: wait for rsp_valid_i.
  - rsp_nack_i = 1 -> ERROR with err_code_o = 01, err_index_o = index.
  - Otherwise advance the word.
- Advance word:
  - If index == WORD_NUMBER-1 -> POLL_ISSUE with try counter 0.
  - Otherwise index++ -> FETCH.
- DELAY:
  - Count ms ticks; after the count reaches the loaded value, advance word.
  - Delay value 0: advance on the next cycle.
  - A delay word as the last word advances to polling after the delay.
- POLL_ISSUE: request rw = 1, addr = STATUS_ADDR, data = 0; same valid/ready rules as ISSUE -> POLL_WAIT.
- POLL_WAIT, on rsp_valid_i:
  - Ready: no NACK and rsp_data_i == READY_VALUE -> DONE.
  - Otherwise the try counter increments. A NACK counts as a failed try, because the device may stretch or NACK while calibrating.
  - Counter reaches POLL_TRIES -> ERROR with err_code_o = 10.
  - Otherwise -> POLL_GAP.
- POLL_GAP: wait POLL_GAP cycles -> POLL_ISSUE.
- busy_o = 1 in every state except IDLE, DONE, ERROR.
- done_o/error_o assert in the cycle the state becomes DONE/ERROR, and are mutually exclusive.
- rsp_valid_i outside WAIT_RSP/POLL_WAIT is ignored.
- Reset mid-operation:
  - Immediate return to reset values; an outstanding request is abandoned.
  - The downstream stage is reset by the same arstn_i.
- Counter widths:
  - ms tick counter: $clog2(CLK_FREQ_HZ/1000) bits.
  - Try counter: $clog2(POLL_TRIES+1) bits.
  - Gap counter: $clog2(POLL_GAP+1) bits.
  - No wrap-around is permitted before the terminal compare.

Test Plan:
- 4-word ROM {0x0B2468, 0x0B2502, 0x05020C, 0x000110}, all ACK, first poll returns 0x0F -> 4 writes in ROM order with the exact addr/data, then 1 read of 0x00FE, done_o = 1, error_o = 0.
- CLK_FREQ_HZ = 10_000 (10 cycles/ms), word 0xFFFF05 between two writes -> second request asserted 50..53 cycles after the first response. Word 0xFFFF00 -> no extra delay.
- NACK on index 2 of 4 -> error_o = 1, err_code_o = 01, err_index_o = 2, no further req_valid_o.
- POLL_TRIES = 3, POLL_GAP = 8, status always 0x00 -> exactly 3 reads spaced ≥ 8 cycles, then err_code_o = 10. Status 0x0F on the 2nd read -> done.
- req_ready_i held low for 20 cycles -> req_valid_o stays 1 with payload unchanged; one request per accept.
- arstn_i asserted mid-DELAY, then start_i -> all outputs 0 after reset; the sequence restarts at word 0. start_i during busy -> ignored.
